// File: rtl/ble_ram_arbiter.sv
// Arbitrates the servant data RAM between the SERV Wishbone master and a buffered UART RX log.
// Define BLE_ARB_BYTE_PACK_EN to pack four received bytes per RAM word instead of one.
module ble_ram_arbiter #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          HI_WATER   = 6,
    parameter logic [31:0] LOG_BASE   = 32'h00C00000,
    parameter logic [31:0] LOG_LIMIT  = 32'h00C10000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [31:0] i_cpu_adr,
    input  logic        i_cpu_cyc,
    input  logic        i_cpu_we,
    input  logic [3:0]  i_cpu_sel,
    input  logic [31:0] i_cpu_dat,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_valid,
    output logic        o_rx_ovf,
    output logic [31:0] o_log_ptr,
    output logic [31:0] o_ram_adr,
    output logic        o_ram_cyc,
    output logic        o_ram_we,
    output logic [3:0]  o_ram_sel,
    output logic [31:0] o_ram_dat,
    input  logic [31:0] i_ram_rdt,
    input  logic        i_ram_ack
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CPU  = 2'd1;
    localparam logic [1:0] S_RX   = 2'd2;

`ifdef BLE_ARB_BYTE_PACK_EN
    localparam logic [31:0] LOG_INC = 32'd1;
`else
    localparam logic [31:0] LOG_INC = 32'd4;
`endif

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rx_ovf;
    logic [31:0]   r_log_ptr;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_byte;
    logic [31:0]   w_ptr_inc;
    logic [31:0]   w_ptr_nxt;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = i_rx_valid && !w_full;
    assign w_pop     = (r_state == S_RX) && i_ram_ack;
    assign w_byte    = r_fifo[r_rd_ptr];
    assign w_ptr_inc = r_log_ptr + LOG_INC;
    // The ring limit is never stored: reaching it reloads the base.
    assign w_ptr_nxt = (w_ptr_inc == LOG_LIMIT) ? LOG_BASE : w_ptr_inc;

    assign o_cpu_rdt = i_ram_rdt;
    assign o_rx_ovf  = r_rx_ovf;
    assign o_log_ptr = r_log_ptr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count >= CW'(HI_WATER))
                    w_state_nxt = S_RX;
                else if (i_cpu_cyc)
                    w_state_nxt = S_CPU;
                else if (!w_empty)
                    w_state_nxt = S_RX;
            end
            // A master abandoning its cycle also frees the RAM.
            S_CPU:   if (i_ram_ack || !i_cpu_cyc) w_state_nxt = S_IDLE;
            S_RX:    if (i_ram_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rx_ovf  <= 1'b0;
            r_log_ptr <= LOG_BASE;
        end else begin
            r_state <= w_state_nxt;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_log_ptr <= w_ptr_nxt;
            end
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            if (i_rx_valid && w_full)
                r_rx_ovf <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge i_wb_clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= i_rx_dat;
    end

    always_comb begin
        o_ram_adr = '0;
        o_ram_cyc = 1'b0;
        o_ram_we  = 1'b0;
        o_ram_sel = '0;
        o_ram_dat = '0;
        o_cpu_ack = 1'b0;
        case (r_state)
            S_CPU: begin
                o_ram_adr = i_cpu_adr;
                o_ram_cyc = i_cpu_cyc;
                o_ram_we  = i_cpu_we;
                o_ram_sel = i_cpu_sel;
                o_ram_dat = i_cpu_dat;
                o_cpu_ack = i_ram_ack;
            end
            S_RX: begin
                o_ram_adr = {r_log_ptr[31:2], 2'b00};
                o_ram_cyc = 1'b1;
                o_ram_we  = 1'b1;
`ifdef BLE_ARB_BYTE_PACK_EN
                o_ram_sel = 4'b0001 << r_log_ptr[1:0];
                o_ram_dat = {4{w_byte}};
`else
                o_ram_sel = 4'b1111;
                o_ram_dat = {24'b0, w_byte};
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ble_ram_arbiter.md
# ble_ram_arbiter

Shares the servant data RAM between the SERV CPU Wishbone master and the BLE UART receive path. A small byte FIFO buffers bytes from `uart_rx`, and each buffered byte is written into a circular log region of RAM. The block sits between `servant` (CPU memory port), `uart_rx` and `servant_ram`. It replaces the combinational rx_done mux, which could corrupt CPU accesses and drop bytes.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: RX byte FIFO entries; power of two, 2..64.
- `HI_WATER`, 6: FIFO fill level at or above which RX is granted over the CPU.
- `LOG_BASE`, 32'h00C00000: first byte address of the log ring; 4-byte aligned.
- `LOG_LIMIT`, 32'h00C10000: first address past the ring; 4-byte aligned, greater than `LOG_BASE`.

Ports:
- `i_wb_clk`, in, 1: system clock.
- `i_wb_rst`, in, 1: reset, asynchronous, active-high.
- `i_cpu_adr`, in, 32: CPU address.
- `i_cpu_cyc`, in, 1: CPU cycle request.
- `i_cpu_we`, in, 1: CPU write enable.
- `i_cpu_sel`, in, 4: CPU byte selects.
- `i_cpu_dat`, in, 32: CPU write data.
- `o_cpu_rdt`, out, 32: CPU read data (pass-through of `i_ram_rdt`).
- `o_cpu_ack`, out, 1: CPU acknowledge.
- `i_rx_dat`, in, 8: received byte.
- `i_rx_valid`, in, 1: one-cycle strobe (`rx_done`); pushes `i_rx_dat`.
- `o_rx_ovf`, out, 1: sticky flag; a byte was dropped because the FIFO was full.
- `o_log_ptr`, out, 32: next log address to be written.
- `o_ram_adr`, out, 32: RAM address.
- `o_ram_cyc`, out, 1: RAM cycle.
- `o_ram_we`, out, 1: RAM write enable.
- `o_ram_sel`, out, 4: RAM byte selects.
- `o_ram_dat`, out, 32: RAM write data.
- `i_ram_rdt`, in, 32: RAM read data.
- `i_ram_ack`, in, 1: RAM acknowledge.

## Operation
- FSM states: IDLE, CPU, RX. The state register is reset to IDLE.
- In IDLE, the grant is chosen in this order:
  - If FIFO count ≥ `HI_WATER`, go to RX.
  - Else if `i_cpu_cyc`, go to CPU.
  - Else if the FIFO is non-empty, go to RX.
  - Else stay in IDLE.
- CPU state:
  - RAM signals mirror the CPU inputs combinationally.
  - `o_cpu_ack = i_ram_ack`.
  - On `i_ram_ack`, go to IDLE.
- RX state:
  - `o_ram_cyc=1`, `o_ram_we=1`, `o_ram_adr={o_log_ptr[31:2],2'b00}`.
  - Data and selects are set per the Configuration section.
  - On `i_ram_ack`: pop the FIFO, advance the pointer, go to IDLE.
- In IDLE, and in RX, `o_ram_cyc` from the CPU is 0 and `o_cpu_ack=0`. The CPU stalls, which Wishbone permits.
- FIFO push and pop:
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - A push when full drops the byte and sets `o_rx_ovf`. The flag clears only on reset.
- Pointer wrap: if pointer + increment == `LOG_LIMIT`, the pointer is loaded with `LOG_BASE`. The pointer never equals `LOG_LIMIT`.
- Reset, including mid-transaction:
  - `o_ram_cyc`, `o_cpu_ack`, `o_ram_we` and `o_rx_ovf` go to 0 immediately.
  - The FIFO is emptied.
  - `o_log_ptr` is set to `LOG_BASE`.
  - Other RAM outputs are 0.
  - A pending CPU cycle is re-arbitrated after reset release.

## Timing
- CPU request sampled in IDLE at edge N:
  - CPU state from edge N+1.
  - With `servant_ram` acking one cycle after `cyc`, `o_cpu_ack` arrives in cycle N+2.
- RX strobe at edge N (FIFO empty, CPU idle):
  - FIFO count is 1 after N.
  - RX state from N+1.
  - RAM write acked in cycle N+2.
  - Pointer advances at N+2.
- After every ack, at least one IDLE cycle with `o_ram_cyc=0` follows. `servant_ram` therefore never sees back-to-back `cyc`.
- Maximum CPU stall is one RX transaction (3 cycles) per HI_WATER event. Sustained UART rate (≥ 87 clocks/byte) keeps the FIFO below `HI_WATER` in normal use.

## Configuration
- `BLE_ARB_BYTE_PACK_EN` defined (byte packing):
  - Bytes are packed four per word.
  - `o_ram_sel` is one-hot at lane `o_log_ptr[1:0]`.
  - `o_ram_dat = {4{byte}}`.
  - The pointer increments by 1.
- Not defined (default):
  - `o_ram_sel=4'b1111`.
  - `o_ram_dat={24'b0,byte}`.
  - The pointer increments by 4, with `o_log_ptr[1:0]` always 0.

## Test plan
- Reset, then idle: `o_log_ptr=32'h00C00000`, `o_ram_cyc=0`, `o_rx_ovf=0`.
- Single byte 8'hA5, no CPU traffic:
  - RAM write to 32'h00C00000 with data 32'h000000A5 and sel 4'hF.
  - `o_log_ptr=32'h00C00004` (packed build: sel 4'b0001, ptr 32'h00C00001).
- CPU read of 32'h00000100 issued in the same cycle as an RX strobe, FIFO otherwise empty:
  - The CPU is served first and `o_cpu_rdt` equals the RAM word.
  - The byte is written in the next RX grant.
- Fill the FIFO to 6 while the CPU holds `cyc`: RX is granted until count < 6, then the CPU acks.
- Push 9 bytes with the RAM ack held low (`FIFO_DEPTH`=8): the 9th byte is dropped, `o_rx_ovf=1`, and the first 8 bytes are later written in order.
- Pointer preloaded near the limit (`LOG_LIMIT`-4) and one byte written: `o_log_ptr` wraps to `LOG_BASE`.
- Assert `i_wb_rst` while in RX with `cyc` high: `o_ram_cyc` drops without waiting for a clock, and the FIFO count is 0.
